// File: rtl/ipm_red_decode_if.sv
// Bundles the job-input and result-output handshakes of the IPM-RED decoder.
interface ipm_red_decode_if #(
  parameter int V = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [V*8-1:0] z;
  logic [V*8-1:0] l1;
  logic [V*8-1:0] l2;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     x1;
  logic [7:0]     x2;
  logic           fault;
  logic           fault_sticky;

  modport master (
    output in_valid, z, l1, l2, out_ready,
    input  in_ready, out_valid, x1, x2, fault, fault_sticky
  );

  modport slave (
    input  in_valid, z, l1, l2, out_ready,
    output in_ready, out_valid, x1, x2, fault, fault_sticky
  );
endinterface

// File: rtl/ipm_red_decode.sv
// Sequential IPM-RED decoder: x1=<L1,Z>, x2=<L2,Z> over GF(2^8), one share per cycle.
// A mismatch between the two inner products flags a fault on the unmasked value.
module ipm_red_decode #(
  parameter int V = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ipm_red_decode_if.slave  bus
);
  localparam int KW = (V > 1) ? $clog2(V) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(V - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     r_state;
  logic [KW-1:0]  r_k;
  logic [V*8-1:0] r_z;
  logic [V*8-1:0] r_l1;
  logic [V*8-1:0] r_l2;
  logic [7:0]     r_acc1;
  logic [7:0]     r_acc2;
  logic [7:0]     r_x1;
  logic [7:0]     r_x2;
  logic           r_fault;
  logic           r_fault_sticky;
  logic           r_out_valid;

  logic [7:0]     w_zk;
  logic [7:0]     w_l1k;
  logic [7:0]     w_l2k;
  logic [7:0]     w_p1;
  logic [7:0]     w_p2;

  // Shift-and-add GF(2^8) multiply, reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  assign w_zk  = r_z[8*int'(r_k) +: 8];
  assign w_l1k = r_l1[8*int'(r_k) +: 8];
  assign w_l2k = r_l2[8*int'(r_k) +: 8];
  assign w_p1  = gmul8(w_l1k, w_zk);
  assign w_p2  = gmul8(w_l2k, w_zk);

  // FIN is a one-cycle stage that registers the finished accumulators into the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_k            <= '0;
      r_acc1         <= 8'h00;
      r_acc2         <= 8'h00;
      r_x1           <= 8'h00;
      r_x2           <= 8'h00;
      r_fault        <= 1'b0;
      r_fault_sticky <= 1'b0;
      r_out_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_z     <= bus.z;
            r_l1    <= bus.l1;
            r_l2    <= bus.l2;
            r_acc1  <= 8'h00;
            r_acc2  <= 8'h00;
            r_k     <= '0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc1 <= r_acc1 ^ w_p1;
          r_acc2 <= r_acc2 ^ w_p2;
          if (r_k == K_LAST) begin
            r_state <= S_FIN;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_FIN: begin
          r_x1           <= r_acc1;
          r_x2           <= r_acc2;
          r_fault        <= (r_acc1 != r_acc2);
          r_fault_sticky <= r_fault_sticky | (r_acc1 != r_acc2);
          r_out_valid    <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (r_state == S_IDLE);
  assign bus.out_valid    = r_out_valid;
  assign bus.x1           = r_x1;
  assign bus.x2           = r_x2;
  assign bus.fault        = r_fault;
  assign bus.fault_sticky = r_fault_sticky;
endmodule

// File: tb/tb_ipm_red_decode.sv
// Directed checks of the IPM-RED decoder at V=4 plus a randomised V=16 run
// against an independent GF(2^8) reference.
module tb_ipm_red_decode;
  logic clk = 1'b0;
  logic rst_n;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  ipm_red_decode_if #(.V(4))  bus4 ();
  ipm_red_decode_if #(.V(16)) bus16 ();

  ipm_red_decode #(.V(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  ipm_red_decode #(.V(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  // Reference multiply: carry-less product then polynomial long division by 0x11B.
  function automatic logic [7:0] gfRef(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    prod = 15'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (prod[i]) prod = prod ^ (15'h11B << (i - 8));
    return prod[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one V=4 job; returns at the negedge just after the accept edge.
  task automatic applyStimulus(input logic [31:0] zv, input logic [31:0] l1v, input logic [31:0] l2v);
    int n;
    n = 0;
    while (bus4.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 32'(bus4.in_ready), 32'd1);
    bus4.z        = zv;
    bus4.l1       = l1v;
    bus4.l2       = l2v;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
  endtask

  task automatic waitOutValid(output int lat);
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic releaseResult();
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [127:0] zz, ll1, ll2;
    logic [7:0]   e1, e2;
    int n;

    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    bus4.z = '0; bus4.l1 = '0; bus4.l2 = '0;
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    bus16.z = '0; bus16.l1 = '0; bus16.l2 = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("rst_in_ready",  32'(bus4.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("rst_x1",        32'(bus4.x1), 32'h00);
    checkOutput("rst_x2",        32'(bus4.x2), 32'h00);
    checkOutput("rst_fault",     32'(bus4.fault), 32'd0);
    checkOutput("rst_sticky",    32'(bus4.fault_sticky), 32'd0);

    // Test 1: clean decode, latency, and input changes during ACC ignored
    applyStimulus(32'h0101_5252, 32'h0302_0001, 32'h0504_0100);
    checkOutput("t1_busy", 32'(bus4.in_ready), 32'd0);
    bus4.z  = 32'hFFFF_FFFF;
    bus4.l1 = 32'h1234_5678;
    waitOutValid(lat);
    checkOutput("t1_latency", 32'(lat), 32'd5);
    checkOutput("t1_x1", 32'(bus4.x1), 32'h53);
    checkOutput("t1_x2", 32'(bus4.x2), 32'h53);
    checkOutput("t1_fault", 32'(bus4.fault), 32'd0);
    checkOutput("t1_sticky", 32'(bus4.fault_sticky), 32'd0);
    releaseResult();
    checkOutput("t1_ov_drop", 32'(bus4.out_valid), 32'd0);
    checkOutput("t1_idle", 32'(bus4.in_ready), 32'd1);
    checkOutput("t1_x1_hold", 32'(bus4.x1), 32'h53);

    // Test 2: faulty sharing, then a clean job keeps sticky set
    applyStimulus(32'h0101_5052, 32'h0302_0001, 32'h0504_0100);
    waitOutValid(lat);
    checkOutput("t2_latency", 32'(lat), 32'd5);
    checkOutput("t2_x1", 32'(bus4.x1), 32'h53);
    checkOutput("t2_x2", 32'(bus4.x2), 32'h51);
    checkOutput("t2_fault", 32'(bus4.fault), 32'd1);
    checkOutput("t2_sticky", 32'(bus4.fault_sticky), 32'd1);
    releaseResult();
    applyStimulus(32'h0101_5252, 32'h0302_0001, 32'h0504_0100);
    waitOutValid(lat);
    checkOutput("t2b_x1", 32'(bus4.x1), 32'h53);
    checkOutput("t2b_fault", 32'(bus4.fault), 32'd0);
    checkOutput("t2b_sticky", 32'(bus4.fault_sticky), 32'd1);
    releaseResult();

    // Test 3: 0x57 * 0x83 = 0xC1; redundancy side gives 0x04 * 0x83 = 0x3A
    applyStimulus(32'h0083_0000, 32'h0057_0001, 32'h0504_0100);
    waitOutValid(lat);
    checkOutput("t3_x1", 32'(bus4.x1), 32'hC1);
    checkOutput("t3_x2", 32'(bus4.x2), 32'h3A);
    checkOutput("t3_fault", 32'(bus4.fault), 32'd1);
    releaseResult();

    // Test 4: backpressure in DONE with an ignored second request
    applyStimulus(32'h0101_5252, 32'h0302_0001, 32'h0504_0100);
    waitOutValid(lat);
    bus4.z        = 32'h0;
    bus4.l1       = 32'h0;
    bus4.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("t4_ov_hold", 32'(bus4.out_valid), 32'd1);
      checkOutput("t4_x1_hold", 32'(bus4.x1), 32'h53);
      checkOutput("t4_x2_hold", 32'(bus4.x2), 32'h53);
      checkOutput("t4_busy", 32'(bus4.in_ready), 32'd0);
    end
    bus4.in_valid = 1'b0;
    releaseResult();
    checkOutput("t4_ov_drop", 32'(bus4.out_valid), 32'd0);
    checkOutput("t4_idle", 32'(bus4.in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_no_second", 32'(bus4.in_ready), 32'd1);

    // Test 5: reset in ACC at k=2 discards the job
    applyStimulus(32'h0101_5252, 32'h0302_0001, 32'h0504_0100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t5_ready", 32'(bus4.in_ready), 32'd1);
    checkOutput("t5_ov", 32'(bus4.out_valid), 32'd0);
    checkOutput("t5_sticky", 32'(bus4.fault_sticky), 32'd0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus4.out_valid !== 1'b0) n++;
    end
    checkOutput("t5_no_result", 32'(n), 32'd0);
    applyStimulus(32'h0101_5252, 32'h0302_0001, 32'h0504_0100);
    waitOutValid(lat);
    checkOutput("t5_latency", 32'(lat), 32'd5);
    checkOutput("t5_x1", 32'(bus4.x1), 32'h53);
    checkOutput("t5_x2", 32'(bus4.x2), 32'h53);
    checkOutput("t5_fault", 32'(bus4.fault), 32'd0);
    releaseResult();

    // Test 6: V=16 random jobs with random handshake gaps
    for (int j = 0; j < 1000; j++) begin
      for (int s = 0; s < 16; s++) begin
        zz[s*8 +: 8]  = 8'($urandom);
        ll1[s*8 +: 8] = 8'($urandom);
        ll2[s*8 +: 8] = 8'($urandom);
      end
      if (j % 4 == 0) ll2 = ll1;
      e1 = 8'h00;
      e2 = 8'h00;
      for (int s = 0; s < 16; s++) begin
        e1 = e1 ^ gfRef(ll1[s*8 +: 8], zz[s*8 +: 8]);
        e2 = e2 ^ gfRef(ll2[s*8 +: 8], zz[s*8 +: 8]);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n = 0;
      while (bus16.in_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      bus16.z        = zz;
      bus16.l1       = ll1;
      bus16.l2       = ll2;
      bus16.in_valid = 1'b1;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      bus16.z        = ~zz;
      n = 0;
      while (bus16.out_valid !== 1'b1 && n < 60) begin
        @(negedge clk);
        n++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checkOutput("t6_job", {15'h0, bus16.out_valid, bus16.x1, bus16.x2},
                  {15'h0, 1'b1, e1, e2});
      checkOutput("t6_fault", 32'(bus16.fault), 32'(e1 != e2));
      bus16.out_ready = 1'b1;
      @(negedge clk);
      bus16.out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
